// File: rtl/dp_ram_data_arb.sv
// dp_ram_data_arb: dual-port byte-addressed data RAM with per-word arbitration.
//   Port A (LSU) and port B (debug/loader) each use a req/gnt handshake. Read
//   data returns with a single-cycle rvalid strobe READ_LATENCY cycles after the
//   grant edge. Same-word conflicts (at least one write) favour A until B has
//   been denied STARVE_LIMIT consecutive times, then B wins once.
// Ports (x = a | b):
//   clk, rst_i          clock, synchronous active-high reset
//   x_req_i / x_gnt_o   request / combinational grant
//   x_addr_i            byte address (low offset bits ignored)
//   x_we_i, x_be_i      write enable, byte enables
//   x_wdata_i           write data
//   x_rvalid_o          read data valid pulse
//   x_rdata_o           read data (held while rvalid is low)
module dp_ram_data_arb #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_BYTES    = 65536,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_i,

  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,

  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH-1:0]   b_rdata_o
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(BE_W);
  localparam int unsigned WIDX_W = ADDR_WIDTH - OFF_W;
  localparam int unsigned WORDS  = NUM_BYTES / BE_W;
  localparam int unsigned MEM_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0]  LIMIT  = 4'(STARVE_LIMIT);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [WIDX_W-1:0] a_word, b_word;
  logic [MEM_AW-1:0] a_idx, b_idx;
  logic              a_in, b_in;
  logic              conflict, b_prio;
  logic [3:0]        starve_cnt;

  assign a_word = a_addr_i[ADDR_WIDTH-1:OFF_W];
  assign b_word = b_addr_i[ADDR_WIDTH-1:OFF_W];
  assign a_idx  = a_word[MEM_AW-1:0];
  assign b_idx  = b_word[MEM_AW-1:0];

  if (OFF_W > 0) begin : g_low
    logic unused_low;
    assign unused_low = ^{a_addr_i[OFF_W-1:0], b_addr_i[OFF_W-1:0]};
  end

  // When the memory covers the whole word space every index is in range.
  if (64'(WORDS) >= (64'd1 << WIDX_W)) begin : g_full
    assign a_in = 1'b1;
    assign b_in = 1'b1;
  end else begin : g_part
    assign a_in = (a_word < WIDX_W'(WORDS));
    assign b_in = (b_word < WIDX_W'(WORDS));
  end

  // ---------------------------------------------------------------- arbitration
  always_comb begin
    conflict = a_req_i && b_req_i && (a_word == b_word) && (a_we_i || b_we_i);
    b_prio   = (starve_cnt == LIMIT);
    a_gnt_o  = 1'b0;
    b_gnt_o  = 1'b0;
    if (!rst_i) begin
      a_gnt_o = a_req_i && !(conflict && b_prio);
      b_gnt_o = b_req_i && !(conflict && !b_prio);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (b_gnt_o) begin
      starve_cnt <= '0;
    end else if (conflict && starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------- writes
  // Grants are forced low in reset, so no write can land then. A and B never
  // write the same word in one cycle because that is a conflict.
  always_ff @(posedge clk) begin
    if (a_gnt_o && a_we_i && a_in) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (a_be_i[i]) mem[a_idx][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
      end
    end
    if (b_gnt_o && b_we_i && b_in) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (b_be_i[i]) mem[b_idx][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- reads
  logic                  a_v1, b_v1;
  logic [DATA_WIDTH-1:0] a_d1, b_d1;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      a_v1 <= 1'b0;
      a_d1 <= '0;
      b_v1 <= 1'b0;
      b_d1 <= '0;
    end else begin
      a_v1 <= a_gnt_o && !a_we_i;
      b_v1 <= b_gnt_o && !b_we_i;
      if (a_gnt_o && !a_we_i) a_d1 <= a_in ? mem[a_idx] : '0;
      if (b_gnt_o && !b_we_i) b_d1 <= b_in ? mem[b_idx] : '0;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  a_v2, b_v2;
    logic [DATA_WIDTH-1:0] a_d2, b_d2;

    always_ff @(posedge clk) begin
      if (rst_i) begin
        a_v2 <= 1'b0;
        a_d2 <= '0;
        b_v2 <= 1'b0;
        b_d2 <= '0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_d2 <= a_d1;
        if (b_v1) b_d2 <= b_d1;
      end
    end

    assign a_rvalid_o = a_v2;
    assign a_rdata_o  = a_d2;
    assign b_rvalid_o = b_v2;
    assign b_rdata_o  = b_d2;
  end else begin : g_lat1
    assign a_rvalid_o = a_v1;
    assign a_rdata_o  = a_d1;
    assign b_rvalid_o = b_v1;
    assign b_rdata_o  = b_d1;
  end

  // ---------------------------------------------------------------- checks
  a_param_latency: assert property (@(posedge clk) (READ_LATENCY == 1 || READ_LATENCY == 2));
  a_param_width:   assert property (@(posedge clk) (DATA_WIDTH % 8 == 0));
  a_param_starve:  assert property (@(posedge clk) (STARVE_LIMIT >= 1 && STARVE_LIMIT <= 15));

  a_hold_a: assert property (@(posedge clk) disable iff (rst_i)
    (a_req_i && !a_gnt_o) |=> (a_req_i && $stable(a_addr_i) && $stable(a_we_i)
                               && $stable(a_be_i) && $stable(a_wdata_i)));
  a_hold_b: assert property (@(posedge clk) disable iff (rst_i)
    (b_req_i && !b_gnt_o) |=> (b_req_i && $stable(b_addr_i) && $stable(b_we_i)
                               && $stable(b_be_i) && $stable(b_wdata_i)));

endmodule
